aes_mix_columns_seq: RTL
========================

Name: aes_mix_columns_seq

Overview:
- Sequential, parametrised MixColumns/InvMixColumns engine for the iterative AES round datapath.
- Accepts one 128-bit state block over a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock.
- Returns the result over a second valid/ready handshake.
- Adds a per-block Skip mode for the final round, which has no MixColumns. This lets one instance serve encrypt, decrypt and last-round passes while trading area for latency.

Parameters:
- COLS_PER_CYCLE, 1, number of 32-bit columns transformed per PROC cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- NUM_PASSES, 4/COLS_PER_CYCLE, derived localparam and not overridable. It is the number of PROC cycles per block.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous reset, active-high.
- Encrypt  in  1  1 = MixColumns, 0 = InvMixColumns. Sampled at input handshake.
- Skip  in  1  1 = pass the block through unchanged. Sampled at input handshake.
- In_valid  in  1  Input_block/Encrypt/Skip valid.
- In_ready  out  1  engine can accept a block.
- Input_block  in  128  AES state, `AES_BLOCK_SIZE.
- Out_valid  out  1  Output_block valid.
- Out_ready  in  1  consumer accepts the output.
- Output_block  out  128  transformed state, driven directly from the state register.
- Busy  out  1  high in PROC or DONE.

Behaviour:
- Column/byte mapping:
  - Columns follow `AES_1ST_WORD..`AES_4TH_WORD and are processed 1st→4th.
  - Within a word, row 0 is bits [7:0] and row 3 is bits [31:24].
  - Enc matrix rows: {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
  - Dec matrix rows: {0E 0B 0D 09}, {09 0E 0B 0D}, {0D 09 0E 0B}, {0B 0D 09 0E}.
  - GF(2^8) reduction polynomial is 0x11B.
- State machine, IDLE / PROC / DONE:
  - IDLE: In_ready=1. On In_valid&&In_ready, latch Input_block into the state register, and latch Encrypt and Skip into mode registers. Clear the pass counter. Go to PROC, or to DONE if Skip=1.
  - PROC: In_ready=0. Each cycle replace columns [cnt*C .. cnt*C+C-1] of the state register with their transform, using the latched mode. cnt increments each cycle. After pass NUM_PASSES-1 is written, go to DONE.
  - DONE: Out_valid=1. Output_block and Out_valid are held stable until Out_valid&&Out_ready, then go to IDLE.
  - DONE never accepts a new block in the same cycle, so In_ready=0 in DONE.
- Latency and throughput:
  - Out_valid rises NUM_PASSES+1 cycles after the accepting cycle (5 / 3 / 2 for C = 1 / 2 / 4).
  - With Skip=1, Out_valid rises 1 cycle after the accepting cycle.
  - With Out_ready held high, a new block is accepted every NUM_PASSES+2 cycles.
- Mode changes: changing Encrypt/Skip/Input_block after acceptance has no effect on the in-flight block.
- Back-pressure: Out_ready low in DONE holds the state indefinitely and leaves the data unchanged. In_valid is ignored while In_ready=0.
- Reset:
  - Rst=1 at any clock edge forces state=IDLE, the state register to 0, the mode registers to 0 and cnt to 0. This applies mid-PROC or mid-DONE; the block is discarded.
  - Out_valid=0, Busy=0 and Output_block=0 from the first cycle after reset.
  - In_ready=1 after reset. Handshakes in a cycle where Rst=1 are ignored.
- Unprocessed columns are never exposed: Out_valid=0 throughout PROC.

Test Plan:
- Enc, C=1, Out_ready=1, column 1 = 0x455313db, other columns 0x01010101 → Out_valid 5 cycles after accept; column 1 = 0xbca14d8e, others = 0x01010101.
- Dec, C=4, all columns = 0xbca14d8e → Out_valid 2 cycles after accept; all columns = 0x455313db. Repeat with 0x9d58dc9f → 0x5c220af2.
- Enc, C=2, columns {0x5c220af2, 0xd5d4d4d4, 0xc6c6c6c6, 0x455313db} → {0x9d58dc9f, 0xd6d7d5d5, 0xc6c6c6c6, 0xbca14d8e} after 3 cycles. Then Dec of that output restores the input (round trip).
- Skip=1, random block → same block with Out_valid 1 cycle after accept. Out_ready low 10 cycles → Output_block stable, In_ready=0 throughout, In_valid pulses ignored.
- Assert Rst for 1 cycle mid-PROC, C=1 after pass 2 → next cycle Out_valid=0, Output_block=0, In_ready=1. A fresh block then completes correctly with no residue.
- Back-to-back stream of 8 random blocks with random Encrypt/Skip and random Out_ready stalls, all C values → every output matches the reference-model MixColumns/InvMixColumns, in order, with no drop or duplicate.

Source files
------------

// File: rtl/aes_mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine with per-block skip.
// Transforms COLS_PER_CYCLE columns per clock over valid/ready handshakes.
//
// Ports:
//   Clk, Rst      clock, synchronous active-high reset
//   Encrypt       1 = MixColumns, 0 = InvMixColumns (sampled at accept)
//   Skip          1 = return block unchanged (sampled at accept)
//   In_valid      Input_block/Encrypt/Skip valid
//   In_ready      engine idle, can accept a block
//   Input_block   128-bit AES state, column 1 in bits [31:0]
//   Out_valid     Output_block valid
//   Out_ready     consumer accepts the output
//   Output_block  transformed state, straight from the state register
//   Busy          block in flight (processing or waiting for output)
module aes_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Encrypt,
    input  logic         Skip,
    input  logic         In_valid,
    output logic         In_ready,
    input  logic [127:0] Input_block,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic [127:0] Output_block,
    output logic         Busy
);

    localparam int NUM_PASSES = 4 / COLS_PER_CYCLE;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
          COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROC,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [127:0]   r_block;
    logic           r_enc;
    logic           r_skip;
    logic [1:0]     r_cnt;

    logic           w_accept;
    logic           w_last;
    logic           w_proc;
    logic [6:0]     w_off     [COLS_PER_CYCLE];
    logic [31:0]    w_col_in  [COLS_PER_CYCLE];
    logic [31:0]    w_col_out [COLS_PER_CYCLE];

    // Multiply by x in GF(2^8), polynomial 0x11B.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Output row 0 of the matrix product; other rows reuse this on a
    // byte-rotated column since both matrices are circulant.
    function automatic logic [7:0] row0(input logic [31:0] w,
                                        input logic enc);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] e0, e1, e2, e3;
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        b0 = w[7:0];
        b1 = w[15:8];
        b2 = w[23:16];
        b3 = w[31:24];
        x2[0] = xt(b0);
        x2[1] = xt(b1);
        x2[2] = xt(b2);
        x2[3] = xt(b3);
        for (int i = 0; i < 4; i++) begin
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
        end
        if (enc) begin
            return x2[0] ^ x2[1] ^ b1 ^ b2 ^ b3;
        end
        e0 = x8[0] ^ x4[0] ^ x2[0];
        e1 = x8[1] ^ x2[1] ^ b1;
        e2 = x8[2] ^ x4[2] ^ b2;
        e3 = x8[3] ^ b3;
        return e0 ^ e1 ^ e2 ^ e3;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c,
                                            input logic enc);
        return {row0({c[23:0], c[31:24]}, enc),
                row0({c[15:0], c[31:16]}, enc),
                row0({c[7:0],  c[31:8]},  enc),
                row0(c, enc)};
    endfunction

    assign w_accept = (r_state == S_IDLE) && In_valid;
    assign w_last   = (r_cnt == 2'(NUM_PASSES - 1));
    assign w_proc   = (r_state == S_PROC) && !r_skip;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        In_ready  = 1'b0;
        Out_valid = 1'b0;
        Busy      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                In_ready = 1'b1;
                if (In_valid) begin
                    w_next = Skip ? S_DONE : S_PROC;
                end
            end
            S_PROC: begin
                Busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                Busy      = 1'b1;
                Out_valid = 1'b1;
                if (Out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Columns handled this pass: cnt*C .. cnt*C+C-1.
    always_comb begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            w_off[j]     = 7'((int'(r_cnt) * COLS_PER_CYCLE + j) * 32);
            w_col_in[j]  = r_block[w_off[j] +: 32];
            w_col_out[j] = mix_col(w_col_in[j], r_enc);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_block <= '0;
            r_enc   <= 1'b0;
            r_skip  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_block <= Input_block;
            r_enc   <= Encrypt;
            r_skip  <= Skip;
            r_cnt   <= '0;
        end else if (w_proc) begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                r_block[w_off[j] +: 32] <= w_col_out[j];
            end
            r_cnt <= w_last ? 2'd0 : r_cnt + 2'd1;
        end
    end

    assign Output_block = r_block;

endmodule
